// File: rtl/wb_imem_loader.sv
// rtl/wb_imem_loader.sv - Wishbone classic initiator that streams an image into instruction memory
//
// wb_imem_fifo: 4-entry word FIFO with flush.
//   wb_clk_i, wb_rst_i : clock, async active-high reset
//   flush              : drop all entries
//   push, push_data    : write one word
//   pop, head          : read one word / current head word
//   empty, count_n     : empty flag, occupancy after this edge
//
// wb_imem_loader: top.
//   wb_clk_i, wb_rst_i            : clock, async active-high reset
//   start, word_count             : begin a load of word_count words (0..256)
//   in_valid, in_data, in_ready   : image word stream
//   wbm_cyc_o .. wbm_ack_i        : Wishbone classic initiator port (writes only)
//   busy, done, error, core_hold  : load status; core_hold keeps the core in reset

module wb_imem_fifo #(
  parameter int DW = 32
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          empty,
  output logic [2:0]    count_n
);

  logic [DW-1:0] mem [4];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    count;
  logic          push_ok;
  logic          pop_ok;

  assign pop_ok  = pop && (count != 3'd0);
  // A full FIFO still takes a word when the same edge pops one.
  assign push_ok = push && ((count != 3'd4) || pop_ok);
  assign empty   = (count == 3'd0);
  assign head    = mem[rd_ptr];

  always_comb begin
    count_n = count;
    if (flush) begin
      count_n = 3'd0;
    end else if (push_ok && !pop_ok) begin
      count_n = count + 3'd1;
    end else if (pop_ok && !push_ok) begin
      count_n = count - 3'd1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      count <= count_n;
      if (flush) begin
        wr_ptr <= 2'd0;
        rd_ptr <= 2'd0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 2'd1;
        if (pop_ok)  rd_ptr <= rd_ptr + 2'd1;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

module wb_imem_loader #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter logic [31:0] ADDR_STEP    = 32'd1,
  parameter logic [3:0]  SEL          = 4'b1111,
  parameter int          TIMEOUT      = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [8:0]  word_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        core_hold
);

  localparam int            TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WR_WAIT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [8:0]    remain;
  logic [TW-1:0] tcnt;
  logic [31:0]   fifo_head;
  logic          fifo_empty;
  logic [2:0]    fifo_count_n;
  logic          push;
  logic          pop;
  logic          load;
  logic          zero_start;
  logic          ack_take;
  logic          tmo;
  logic          last_word;

  assign push      = in_valid && in_ready;
  assign last_word = (remain == 9'd1);
  assign core_hold = busy;

  wb_imem_fifo #(.DW(32)) u_fifo (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .flush     (tmo),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count_n   (fifo_count_n)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    zero_start = 1'b0;
    pop        = 1'b0;
    ack_take   = 1'b0;
    tmo        = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          if (word_count == 9'd0) begin
            zero_start = 1'b1;
            state_n    = S_DONE;
          end else begin
            load    = 1'b1;
            state_n = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = S_WR_WAIT;
        end
      end
      S_WR_WAIT: begin
        // An ack on the last timeout cycle still completes the write.
        if (wbm_ack_i) begin
          ack_take = 1'b1;
          state_n  = last_word ? S_DONE : S_FETCH;
        end else if (tcnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_n = S_ERROR;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'b0000;
      wbm_adr_o <= BASE_ADDRESS;
      wbm_dat_o <= 32'd0;
      remain    <= 9'd0;
      tcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (pop) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= 1'b1;
        wbm_sel_o <= SEL;
        wbm_dat_o <= fifo_head;
      end else if (ack_take || tmo) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_sel_o <= 4'b0000;
      end

      if (load)          wbm_adr_o <= BASE_ADDRESS;
      else if (ack_take) wbm_adr_o <= wbm_adr_o + ADDR_STEP;

      if (load)          remain <= word_count;
      else if (ack_take) remain <= remain - 9'd1;

      if (pop)                       tcnt <= '0;
      else if (state == S_WR_WAIT)   tcnt <= tcnt + 1'b1;

      if (tmo)       error <= 1'b1;
      else if (load) error <= 1'b0;

      done     <= zero_start || (ack_take && last_word);
      busy     <= (state_n == S_FETCH) || (state_n == S_WR_WAIT);
      in_ready <= (state_n != S_ERROR) && (fifo_count_n != 3'd4);
    end
  end

endmodule

// File: tb/tb_wb_imem_loader.sv
// tb/tb_wb_imem_loader.sv - self-checking bench for wb_imem_loader
module tb_wb_imem_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] STEP = 32'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  word_count = 9'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack = 1'b0;
  logic        busy, done, error, core_hold;

  wb_imem_loader dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .start      (start),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we),
    .wbm_sel_o  (sel),
    .wbm_adr_o  (adr),
    .wbm_dat_o  (dat),
    .wbm_ack_i  (ack),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .core_hold  (core_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int ack_delay = 2;   // 0 = slave never acks
  bit src_gap = 1'b0;
  logic [31:0] src_q[$];
  logic [31:0] acc_q[$];
  int wr_idx, wr_cnt, done_cnt, busy_cyc, hold_cyc, stb_cyc, overlap, age, last_run;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Slave + scoreboard: ack after ack_delay strobe cycles; each write must carry
  // the next accepted stream word at BASE + index*STEP.
  initial begin
    logic [31:0] exp_w;
    age = 0;
    last_run = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        age = 0;
        ack = 1'b0;
      end else begin
        if (busy) busy_cyc++;
        if (core_hold) hold_cyc++;
        if (done) done_cnt++;
        if (done && busy) overlap++;
        if (stb) stb_cyc++;
        if (!stb) chk("idle_sel", sel, 4'h0);
        if (cyc && stb) age++;
        else begin
          if (age > 0) last_run = age;
          age = 0;
        end
        ack = (ack_delay != 0) && cyc && stb && (age == ack_delay);
        if (ack) begin
          chk("wr_adr", adr, BASE + STEP * 32'(wr_idx));
          if (acc_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL wr_dat: got %0h expected none (no word outstanding)", dat);
          end else begin
            exp_w = acc_q.pop_front();
            chk("wr_dat", dat, exp_w);
          end
          chk("wr_sel", sel, 4'hF);
          chk("wr_we", we, 1'b1);
          wr_idx++;
          wr_cnt++;
        end
      end
    end
  end

  // Word source: a word counts as accepted when valid meets ready at the next edge.
  initial begin
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (rst || src_q.size() == 0 || (src_gap && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = src_q[0];
        if (in_ready) begin
          w = src_q.pop_front();
          acc_q.push_back(w);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clr();
    wr_idx = 0; wr_cnt = 0; done_cnt = 0; busy_cyc = 0;
    hold_cyc = 0; stb_cyc = 0; overlap = 0; last_run = 0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    word_count = 9'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    int i;
    i = 0;
    while (done_cnt == 0 && i < limit) begin
      tick();
      i++;
    end
    if (done_cnt == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got no done expected done within %0d cycles", name, limit);
    end
  endtask

  typedef struct {
    int          cnt;
    logic [31:0] first;
    int          d;
    int          exp_busy;
    int          exp_stb;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int i, n, d;
    tbl[0] = '{3, 32'h0000_0011, 2, 9, 6};
    tbl[1] = '{1, 32'h0BAD_F00D, 1, 2, 1};
    tbl[2] = '{4, 32'h1357_9BDF, 3, 16, 12};
    tbl[3] = '{5, 32'h0102_0304, 2, 15, 10};
    tbl[4] = '{0, 32'h0000_0000, 2, 0, 0};

    // Reset state
    tick(3);
    rst = 1'b0;
    tick();
    chk("rst_cyc", cyc, 1'b0);
    chk("rst_stb", stb, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_sel", sel, 4'h0);
    chk("rst_adr", adr, BASE);
    chk("rst_dat", dat, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_hold", core_hold, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // Table-driven loads against a preloaded FIFO
    for (int k = 0; k < 5; k++) begin
      ack_delay = tbl[k].d;
      src_gap = 1'b0;
      for (int j = 0; j < tbl[k].cnt; j++) src_q.push_back(tbl[k].first * 32'(j + 1));
      tick(8);
      clr();
      do_start(tbl[k].cnt);
      if (tbl[k].cnt == 0) tick(3);
      else wait_done("tbl_done", 300);
      tick(2);
      chk("tbl_writes", wr_cnt, tbl[k].cnt);
      chk("tbl_done_cnt", done_cnt, 1);
      chk("tbl_busy_cyc", busy_cyc, tbl[k].exp_busy);
      chk("tbl_hold_cyc", hold_cyc, tbl[k].exp_busy);
      chk("tbl_stb_cyc", stb_cyc, tbl[k].exp_stb);
      chk("tbl_done_overlap", overlap, 0);
      chk("tbl_error", error, 1'b0);
      if (tbl[k].cnt != 0) chk("tbl_adr_end", adr, BASE + STEP * 32'(tbl[k].cnt));
      chk("tbl_leftover", acc_q.size(), 0);
    end

    // Backpressure: 6 words, only 4 fit before start
    ack_delay = 2;
    for (int j = 0; j < 6; j++) src_q.push_back(32'hA000_0000 + 32'(j));
    tick(10);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_accepted", acc_q.size(), 4);
    clr();
    do_start(6);
    wait_done("bp_done", 300);
    tick(2);
    chk("bp_writes", wr_cnt, 6);
    chk("bp_src_left", src_q.size(), 0);

    // Starved source
    clr();
    do_start(2);
    tick(20);
    chk("starve_stb", stb_cyc, 0);
    chk("starve_error", error, 1'b0);
    chk("starve_busy", busy, 1'b1);
    src_q.push_back(32'h5555_0001);
    tick(6);
    chk("starve_first_write", wr_cnt, 1);
    src_q.push_back(32'h5555_0002);
    wait_done("starve_done", 100);
    tick(2);
    chk("starve_writes", wr_cnt, 2);

    // Timeout: slave never acks; queued words must be flushed
    ack_delay = 0;
    src_q.push_back(32'hDEAD_0001);
    src_q.push_back(32'hDEAD_0002);
    src_q.push_back(32'hDEAD_0003);
    tick(6);
    clr();
    do_start(2);
    i = 0;
    while (!error && i < 100) begin
      tick();
      i++;
    end
    chk("to_error", error, 1'b1);
    chk("to_stb", stb, 1'b0);
    chk("to_busy", busy, 1'b0);
    chk("to_in_ready", in_ready, 1'b0);
    chk("to_stb_run", last_run, 16);
    chk("to_writes", wr_cnt, 0);
    acc_q.delete();
    src_q.push_back(32'hC0DE_0001);
    src_q.push_back(32'hC0DE_0002);
    tick(4);
    chk("to_in_ready_hold", in_ready, 1'b0);
    chk("to_error_sticky", error, 1'b1);
    ack_delay = 2;
    clr();
    do_start(2);
    chk("to_error_clr", error, 1'b0);
    wait_done("to_reload_done", 100);
    tick(2);
    chk("to_reload_writes", wr_cnt, 2);
    chk("to_reload_adr", adr, BASE + STEP * 32'd2);

    // Zero count, then start ignored mid-load
    clr();
    do_start(0);
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    tick(4);
    chk("zero_stb", stb_cyc, 0);
    chk("zero_done_cnt", done_cnt, 1);
    src_q.push_back(32'h7777_0001);
    src_q.push_back(32'h7777_0002);
    tick(4);
    clr();
    do_start(2);
    tick(2);
    do_start(7);
    wait_done("ign_done", 100);
    tick(5);
    chk("ign_writes", wr_cnt, 2);
    chk("ign_done_cnt", done_cnt, 1);
    chk("ign_busy", busy, 1'b0);
    chk("ign_adr", adr, BASE + STEP * 32'd2);

    // Mid-load reset
    src_q.push_back(32'h9999_0001);
    src_q.push_back(32'h9999_0002);
    tick(4);
    clr();
    do_start(2);
    i = 0;
    while (!stb && i < 30) begin
      tick();
      i++;
    end
    chk("mr_stb_seen", stb, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mr_cyc", cyc, 1'b0);
    chk("mr_stb", stb, 1'b0);
    chk("mr_sel", sel, 4'h0);
    chk("mr_adr", adr, BASE);
    chk("mr_dat", dat, 32'd0);
    chk("mr_busy", busy, 1'b0);
    chk("mr_hold", core_hold, 1'b0);
    chk("mr_in_ready", in_ready, 1'b1);
    @(negedge clk);
    #1;
    src_q.delete();
    acc_q.delete();
    rst = 1'b0;
    tick();
    src_q.push_back(32'h4242_0001);
    src_q.push_back(32'h4242_0002);
    tick(4);
    clr();
    do_start(2);
    wait_done("mr_reload_done", 100);
    tick(2);
    chk("mr_reload_writes", wr_cnt, 2);

    // Randomized loads with a gappy source and varying ack latency
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 10);
      d = $urandom_range(1, 4);
      ack_delay = d;
      src_gap = 1'b1;
      for (int j = 0; j < n; j++) src_q.push_back($urandom);
      clr();
      do_start(n);
      wait_done("rnd_done", 1000);
      tick(2);
      chk("rnd_writes", wr_cnt, n);
      chk("rnd_done_cnt", done_cnt, 1);
      chk("rnd_error", error, 1'b0);
      chk("rnd_adr_end", adr, BASE + STEP * 32'(n));
      chk("rnd_stb_cyc", stb_cyc, n * d);
      chk("rnd_busy_min", busy_cyc >= n * (d + 1), 1'b1);
      chk("rnd_done_overlap", overlap, 0);
      chk("rnd_leftover", acc_q.size() + src_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_imem_loader.md
# wb_imem_loader

Wishbone classic initiator that streams a program image into the instruction-memory slave of the MemSoC and keeps the RISC-V core held off while loading. Words arrive on a valid/ready stream into a 4-entry FIFO. An FSM issues one single-word Wishbone write per word to consecutive addresses, then reports done or error. It sits between a host-side word source (UART/SPI deserializer or test harness) and the memory slave's `wbs_*` port.

## Interface
- `BASE_ADDRESS`, 32'h3000_0000, address of the first word written.
- `ADDR_STEP`, 32'd1, address increment per word; 1 = word-addressed slave, 4 = byte-addressed.
- `SEL`, 4'b1111, byte-select driven on every write.
- `TIMEOUT`, 16, cycles to wait for `wbm_ack_i` before flagging error; minimum 2.
- `wb_clk_i` in 1: the single clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `start` in 1: begin a load; sampled only in IDLE/DONE/ERROR.
- `word_count` in 9: number of words to load, 0..256; latched on accepted `start`.
- `in_valid` in 1: `in_data` is valid.
- `in_data` in 32: image word.
- `in_ready` out 1: FIFO not full; a word is pushed when `in_valid && in_ready`.
- `wbm_cyc_o` in/out: out 1: bus cycle.
- `wbm_stb_o` out 1: strobe.
- `wbm_we_o` out 1: write enable; 1 whenever `stb` is high.
- `wbm_sel_o` out 4: `SEL` during a strobe, else 0.
- `wbm_adr_o` out 32: current write address.
- `wbm_dat_o` out 32: current write data.
- `wbm_ack_i` in 1: slave acknowledge.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky ack-timeout flag.
- `core_hold` out 1: equals `busy`; drives core reset during loading.

## Operation
- FIFO: 4 entries, 3-bit occupancy. Push is accepted in any state except ERROR, where `in_ready` = 0. Simultaneous push and pop on a full FIFO is allowed and leaves occupancy unchanged. The FIFO is flushed on entry to ERROR.
- States are IDLE, FETCH, WR_WAIT, DONE, ERROR.
- IDLE/DONE/ERROR on `start`:
  - If `word_count` = 0, go to DONE and pulse `done`; `busy` stays low.
  - Otherwise latch the count, set address = `BASE_ADDRESS`, clear `error`, and go to FETCH.
- FETCH: if the FIFO is non-empty, pop into `wbm_dat_o` and assert `cyc`/`stb`/`we`/`sel`. Go to WR_WAIT and clear the timeout counter. If the FIFO is empty, stay in FETCH with no timeout.
- WR_WAIT: the bus outputs are held stable.
  - On `wbm_ack_i`: deassert the strobe, add `ADDR_STEP` to the address (wraps mod 2^32), and decrement the count. If the count reaches 0, go to DONE and pulse `done`; otherwise go to FETCH.
  - If the counter reaches `TIMEOUT-1` without ack: deassert the strobe, set `error`, and go to ERROR.
- DONE: idle, keeps the last address. `start` is ignored while `busy`.
- `busy` = state in {FETCH, WR_WAIT}.
- A late ack arriving after ERROR is ignored.

## Timing
- All outputs are registered. Reset values:
  - `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` = 0.
  - `wbm_sel_o` = 0.
  - `wbm_adr_o` = `BASE_ADDRESS`.
  - `wbm_dat_o` = 0.
  - `busy`, `done`, `error`, `core_hold` = 0.
  - `in_ready` = 1.
  - FIFO empty, state IDLE.
- `start` accepted at edge N gives `busy` = 1 after N. If the FIFO was non-empty, the strobe is high after N+1.
- Ack sampled at edge M gives the strobe low after M. The next strobe rises after M+1, so there is at least one idle cycle between writes. Throughput is one word per 3 cycles against a 1-cycle-ack slave.
- The last ack at edge M gives `done` high for the cycle after M, and `busy` low in that same cycle.
- `in_ready` falls the cycle after the 4th unpopped push.
- Reset asserted mid-transfer immediately drops `cyc`/`stb` and all status; the partial image is not retried.

## Test plan
- **Basic load:**
  - Stimulus: preload 3 words (0x11, 0x22, 0x33), `word_count` = 3, ack one cycle after `stb`.
  - Required: writes to 0x3000_0000, _0001, _0002 with matching data and `sel` = 4'b1111; `done` pulses once; `busy` is high for 9 cycles.
- **Backpressure:**
  - Stimulus: push 6 words back-to-back with no start.
  - Required: `in_ready` low after 4 accepted; after `start`, words 5 and 6 are accepted as the FIFO drains, and all 6 are written in order.
- **Starved source:**
  - Stimulus: `start` with `word_count` = 2 and an empty FIFO; push a word after 20 cycles.
  - Required: no strobe and no error while empty; the write follows the push.
- **Timeout:**
  - Stimulus: slave never acks, `TIMEOUT` = 16.
  - Required: strobe high for exactly 16 cycles, then `error` = 1, `busy` = 0, FIFO empty, `in_ready` = 0.
  - Then `start` clears `error` and a new load proceeds.
- **Zero count and ignored start:**
  - Stimulus: `word_count` = 0, then `start` pulsed during a 2-word load.
  - Required: `word_count` = 0 gives a `done` pulse with no bus activity; the mid-load `start` has no effect.
- **Mid-load reset:**
  - Stimulus: assert `wb_rst_i` while `stb` is high.
  - Required: all outputs return to reset values asynchronously; a fresh load afterwards starts at `BASE_ADDRESS`.
